// File: rtl/multi_pulse_shortener.sv
// multi_pulse_shortener: per-channel debounce-and-shorten pulse generator.
// Every channel qualifies a level input over DEBOUNCE consecutive enabled high
// samples, then emits exactly one PULSE_LEN-cycle pulse. The channel re-arms
// only after it has seen the input low.
//
// Ports:
//   clk           - single clock, rising edge
//   rst_n         - asynchronous active-low reset
//   i_enable      - 1 = new inputs may qualify
//   i_is_valid    - per-channel level inputs
//   o_valid       - per-channel shortened pulse (registered)
//   o_held        - per-channel 1 while the channel is in FIRE or HOLD (registered)
//   o_any_valid   - OR of all o_valid bits (registered)
//   o_event_count - pulses issued across all channels since reset, wraps at 2^16
module multi_pulse_shortener #(
   parameter int unsigned CHANNELS  = 8,
   parameter int unsigned DEBOUNCE  = 2,
   parameter int unsigned PULSE_LEN = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_enable,
   input  logic [CHANNELS-1:0] i_is_valid,
   output logic [CHANNELS-1:0] o_valid,
   output logic [CHANNELS-1:0] o_held,
   output logic                o_any_valid,
   output logic [15:0]         o_event_count
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned EVT_W = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_QUAL = 2'd1;
   localparam logic [1:0] ST_FIRE = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] PUL_LAST = CNT_W'(PULSE_LEN);

   logic [1:0]       r_state [CHANNELS];
   logic [CNT_W-1:0] r_qcnt  [CHANNELS];
   logic [CNT_W-1:0] r_pcnt  [CHANNELS];
   logic [1:0]       w_state_nxt [CHANNELS];
   logic [CNT_W-1:0] w_qcnt_nxt  [CHANNELS];
   logic [CNT_W-1:0] w_pcnt_nxt  [CHANNELS];

   logic [CHANNELS-1:0] r_valid;
   logic [CHANNELS-1:0] r_held;
   logic                r_any_valid;
   logic [EVT_W-1:0]    r_event_count;
   logic [CHANNELS-1:0] w_valid_nxt;
   logic [CHANNELS-1:0] w_held_nxt;
   logic [EVT_W-1:0]    w_entries;
   logic [EVT_W-1:0]    w_event_count_nxt;

   // Next-state logic for every channel, plus the count of FIRE entries this edge
   always_comb begin
      w_entries   = '0;
      w_valid_nxt = '0;
      w_held_nxt  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_qcnt_nxt[i]  = r_qcnt[i];
         w_pcnt_nxt[i]  = r_pcnt[i];
         case (r_state[i])
            ST_IDLE: begin
               if (i_is_valid[i] && i_enable) begin
                  if (DEB_LAST == CNT_W'(1)) begin
                     w_state_nxt[i] = ST_FIRE;
                     w_qcnt_nxt[i]  = '0;
                  end else begin
                     w_state_nxt[i] = ST_QUAL;
                     w_qcnt_nxt[i]  = CNT_W'(1);
                  end
               end
            end
            ST_QUAL: begin
               // Any low or disabled sample restarts qualification from zero
               if (i_is_valid[i] && i_enable) begin
                  if (r_qcnt[i] + CNT_W'(1) == DEB_LAST) begin
                     w_state_nxt[i] = ST_FIRE;
                     w_qcnt_nxt[i]  = '0;
                  end else begin
                     w_qcnt_nxt[i] = r_qcnt[i] + CNT_W'(1);
                  end
               end else begin
                  w_state_nxt[i] = ST_IDLE;
                  w_qcnt_nxt[i]  = '0;
               end
            end
            ST_FIRE: begin
               // The pulse always runs to full length; input only picks the exit state
               if (r_pcnt[i] + CNT_W'(1) == PUL_LAST) begin
                  w_pcnt_nxt[i]  = '0;
                  w_state_nxt[i] = i_is_valid[i] ? ST_HOLD : ST_IDLE;
               end else begin
                  w_pcnt_nxt[i] = r_pcnt[i] + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (!i_is_valid[i]) begin
                  w_state_nxt[i] = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt[i] = ST_IDLE;
               w_qcnt_nxt[i]  = '0;
               w_pcnt_nxt[i]  = '0;
            end
         endcase
         w_valid_nxt[i] = (w_state_nxt[i] == ST_FIRE);
         w_held_nxt[i]  = (w_state_nxt[i] == ST_FIRE) || (w_state_nxt[i] == ST_HOLD);
         if ((w_state_nxt[i] == ST_FIRE) && (r_state[i] != ST_FIRE)) begin
            w_entries = w_entries + EVT_W'(1);
         end
      end
      w_event_count_nxt = r_event_count + w_entries;
   end

   // State and output registers; outputs mirror the registered state exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_state[i] <= ST_IDLE;
            r_qcnt[i]  <= '0;
            r_pcnt[i]  <= '0;
         end
         r_valid       <= '0;
         r_held        <= '0;
         r_any_valid   <= 1'b0;
         r_event_count <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_qcnt[i]  <= w_qcnt_nxt[i];
            r_pcnt[i]  <= w_pcnt_nxt[i];
         end
         r_valid       <= w_valid_nxt;
         r_held        <= w_held_nxt;
         r_any_valid   <= |w_valid_nxt;
         r_event_count <= w_event_count_nxt;
      end
   end

   assign o_valid       = r_valid;
   assign o_held        = r_held;
   assign o_any_valid   = r_any_valid;
   assign o_event_count = r_event_count;

endmodule

// File: doc/multi_pulse_shortener.md
MULTI_PULSE_SHORTENER -- requirements
Module: multi_pulse_shortener

Interface
REQ-001 Parameter CHANNELS, default 8: number of independent input/output channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE, default 2: consecutive high samples required to qualify an input, legal range 1..255.
REQ-003 Parameter PULSE_LEN, default 1: output pulse length in clock cycles, legal range 1..255.
REQ-004 Clock  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of Clock.
REQ-006 Enable  input  1  1 = qualification of new inputs allowed.
REQ-007 isValid  input  CHANNELS  per-channel level input, synchronous to Clock.
REQ-008 Valid  output  CHANNELS  per-channel shortened pulse, registered.
REQ-009 Held  output  CHANNELS  per-channel 1 while the channel is in FIRE or HOLD.
REQ-010 AnyValid  output  1  OR of all Valid bits, registered.
REQ-011 EventCount  output  16  total pulses issued across all channels since reset.

Function
REQ-012 Each channel SHALL run an independent FSM with states IDLE, QUAL, FIRE, HOLD, plus an 8-bit qualify counter and an 8-bit pulse counter.
REQ-013 IDLE: isValid=1 and Enable=1 -> QUAL with qualify count 1, or FIRE directly when DEBOUNCE=1; otherwise stay in IDLE.
REQ-014 QUAL: isValid=0 or Enable=0 -> IDLE, count cleared; isValid=1 increments count; on reaching DEBOUNCE -> FIRE.
REQ-015 FIRE: pulse counter counts cycles; after PULSE_LEN cycles in FIRE -> HOLD if isValid=1, IDLE if isValid=0.
REQ-016 FIRE SHALL always complete the full PULSE_LEN cycles, regardless of isValid or Enable during the pulse.
REQ-017 HOLD: isValid=0 -> IDLE; otherwise stay; Enable is ignored in HOLD.
REQ-018 Valid[i] SHALL be 1 exactly in cycles where channel i state register = FIRE, with no combinational path from isValid.
REQ-019 Latency: isValid[i] high from edge k onward gives Valid[i] high after edge k+DEBOUNCE-1, for exactly PULSE_LEN cycles.
REQ-020 Exactly one pulse per qualified high level; re-arming requires a return to IDLE, i.e. at least one low sample.
REQ-021 A low glitch of one sample during QUAL SHALL restart qualification from zero.
REQ-022 A low sample during FIRE is not remembered, apart from selecting IDLE instead of HOLD at FIRE exit.
REQ-023 EventCount SHALL add the number of channels entering FIRE on each edge (0..CHANNELS, simultaneous entries all counted) and wrap modulo 2^16.
REQ-024 AnyValid SHALL equal the OR of Valid in the same cycle.
REQ-025 Channels SHALL not interact except through AnyValid and EventCount.

Reset
REQ-026 Reset=0 SHALL asynchronously set all channels to IDLE, clear all counters, and drive Valid=0, Held=0, AnyValid=0, EventCount=0.
REQ-027 Reset asserted mid-pulse SHALL truncate the pulse immediately; after release, an input still high SHALL requalify from zero.
REQ-028 Reset deassertion SHALL take effect at the first rising Clock edge after release; no state changes on the release edge itself beyond that.

Verification
REQ-029 Defaults, ch0 isValid held high 10 cycles from edge 5 -> Valid[0]=1 only in the cycle after edge 6, Held[0]=1 from edge 6 until isValid falls, EventCount=1.
REQ-030 DEBOUNCE=3, ch2 input pattern 1,1,0,1,1,1 -> exactly one pulse, after the 6th sample; EventCount=1.
REQ-031 PULSE_LEN=4, input high for 2 cycles then low -> Valid high 4 cycles, FSM returns to IDLE (not HOLD), Held=0 afterwards.
REQ-032 All 8 channels rise on the same edge -> all Valid bits high in the same cycle, AnyValid=1, EventCount increments by 8 on one edge; starting from 16'hFFFC, EventCount wraps to 16'h0004.
REQ-033 Reset=0 asynchronously in the middle of a PULSE_LEN=4 pulse -> Valid=0 immediately without a clock edge; input still high after release -> new pulse after DEBOUNCE samples.
REQ-034 Enable=0 during QUAL -> channel returns to IDLE and no pulse is issued; Enable=0 during FIRE -> pulse still completes.
